// File: rtl/top_serial_bcd.sv
// ============================================================================
// Module      : top_serial_bcd
// Description : Latches one of three 16-bit binary operands, converts it to
//               5-digit BCD by double-dabble and transmits the 20 BCD bits
//               serially, most significant digit first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module top_serial_bcd (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_press,
    input  logic        is_op1,
    input  logic        is_op2,
    input  logic        is_res,
    input  logic [15:0] op1,
    input  logic [15:0] op2,
    input  logic [15:0] res,
    output logic        data,
    output logic        data_enable,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_SHIFT   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam int          NUM_DIGITS  = 5;
    localparam logic [4:0]  C_CONV_LAST = 5'd15;
    localparam logic [4:0]  C_SHIFT_LAST = 5'd19;

    state_t      r_state;
    logic [15:0] r_bin;
    logic [19:0] r_bcd;
    logic [4:0]  r_cnt;
    logic        r_data;
    logic        r_data_enable;
    logic        r_busy;
    logic        r_done;

    logic        w_start;
    logic [15:0] w_sel_value;
    logic [19:0] w_bcd_adj;
    logic [19:0] w_bcd_next;
    logic [15:0] w_bin_next;

    assign w_start = btn_press & (is_op1 | is_op2 | is_res);

    always_comb begin
        w_sel_value = res;
        if (is_op1) begin
            w_sel_value = op1;
        end else if (is_op2) begin
            w_sel_value = op2;
        end
    end

    // Add-3 correction keeps every nibble a valid decimal digit after the shift.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                                          (r_bcd[4*gi +: 4] + 4'd3) :
                                          r_bcd[4*gi +: 4];
        end
    endgenerate

    assign {w_bcd_next, w_bin_next} = {w_bcd_adj[18:0], r_bin, 1'b0};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_bin         <= 16'd0;
            r_bcd         <= 20'd0;
            r_cnt         <= 5'd0;
            r_data        <= 1'b0;
            r_data_enable <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_data        <= 1'b0;
                    r_data_enable <= 1'b0;
                    r_done        <= 1'b0;
                    if (w_start) begin
                        r_bin   <= w_sel_value;
                        r_bcd   <= 20'd0;
                        r_cnt   <= 5'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_CONVERT;
                    end
                end

                S_CONVERT: begin
                    r_bin <= w_bin_next;
                    r_bcd <= w_bcd_next;
                    if (r_cnt == C_CONV_LAST) begin
                        // Present the first serial bit in the same cycle SHIFT starts.
                        r_cnt         <= 5'd0;
                        r_data        <= w_bcd_next[19];
                        r_data_enable <= 1'b1;
                        r_state       <= S_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end

                S_SHIFT: begin
                    r_bcd <= {r_bcd[18:0], 1'b0};
                    if (r_cnt == C_SHIFT_LAST) begin
                        r_cnt         <= 5'd0;
                        r_data        <= 1'b0;
                        r_data_enable <= 1'b0;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        r_state       <= S_DONE;
                    end else begin
                        r_cnt  <= r_cnt + 5'd1;
                        r_data <= r_bcd[18];
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign data        = r_data;
    assign data_enable = r_data_enable;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_top_serial_bcd.sv
// ============================================================================
// Module      : tb_top_serial_bcd
// Description : Self-checking bench for top_serial_bcd with a decimal-arithmetic
//               reference model, directed vectors and randomized transactions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_top_serial_bcd;

    logic        clk;
    logic        reset;
    logic        btn_press;
    logic        is_op1;
    logic        is_op2;
    logic        is_res;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [15:0] res;
    logic        data;
    logic        data_enable;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    top_serial_bcd dut (
        .clk         (clk),
        .reset       (reset),
        .btn_press   (btn_press),
        .is_op1      (is_op1),
        .is_op2      (is_op2),
        .is_res      (is_res),
        .op1         (op1),
        .op2         (op2),
        .res         (res),
        .data        (data),
        .data_enable (data_enable),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;      // {is_op1, is_op2, is_res}
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        int unsigned exp_val;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned model_select(input logic [2:0] sel, input logic [15:0] a,
                                                 input logic [15:0] b, input logic [15:0] r);
        if (sel[2]) return int'(a);
        if (sel[1]) return int'(b);
        return int'(r);
    endfunction

    function automatic logic [19:0] model_bcd(input int unsigned v);
        logic [19:0] out;
        int unsigned rem;
        rem = v;
        out = 20'd0;
        for (int d = 0; d < 5; d++) begin
            out[4*d +: 4] = 4'(rem % 10);
            rem = rem / 10;
        end
        return out;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_data"}, 32'(data), 32'd0);
        check({tag, "_de"},   32'(data_enable), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // One full transaction; abort_at>0 pulses reset asynchronously in that cycle.
    task automatic run_txn(input logic [2:0] sel, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] r, input int unsigned exp_val,
                           input bit disturb, input int abort_at);
        logic [19:0] bcd;
        int          busy_cnt;
        int          done_cnt;
        logic        exp_de;
        logic        exp_data;
        bcd      = model_bcd(exp_val);
        busy_cnt = 0;
        done_cnt = 0;
        @(negedge clk);
        {is_op1, is_op2, is_res} = sel;
        op1 = a; op2 = b; res = r;
        btn_press = 1'b1;
        @(negedge clk);
        btn_press = 1'b0;
        for (int k = 1; k <= 37; k++) begin
            if (k > 1) @(negedge clk);
            exp_de   = (k >= 17) && (k <= 36);
            exp_data = exp_de ? bcd[19 - (k - 17)] : 1'b0;
            check("busy", 32'(busy), 32'(k <= 36));
            check("data_enable", 32'(data_enable), 32'(exp_de));
            check("data", 32'(data), 32'(exp_data));
            check("done", 32'(done), 32'(k == 37));
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (k == abort_at) begin
                #2 reset = 1'b1;
                #1 check_idle_outputs("abort");
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            if (disturb && k == 5) begin
                btn_press = 1'b1;
                {is_op1, is_op2, is_res} = 3'b111 ^ sel;
                op1 = ~a; op2 = ~b; res = ~r;
            end
            if (disturb && k == 6) btn_press = 1'b0;
        end
        check("busy_cycles", 32'(busy_cnt), 32'd36);
        check("done_pulses", 32'(done_cnt), 32'd1);
        @(negedge clk);
        check("post_done", 32'(done), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
    endtask

    vec_t vecs[5];

    initial begin
        reset = 1'b1;
        btn_press = 1'b0;
        is_op1 = 1'b0; is_op2 = 1'b0; is_res = 1'b0;
        op1 = 16'd0; op2 = 16'd0; res = 16'd0;

        vecs[0] = '{sel: 3'b100, a: 16'hFFFF, b: 16'h1234, r: 16'h4321, exp_val: 65535};
        vecs[1] = '{sel: 3'b010, a: 16'hAAAA, b: 16'h7986, r: 16'h0001, exp_val: 31110};
        vecs[2] = '{sel: 3'b001, a: 16'h5555, b: 16'h0F0F, r: 16'h6590, exp_val: 26000};
        vecs[3] = '{sel: 3'b110, a: 16'h0000, b: 16'hFFFF, r: 16'hFFFF, exp_val: 0};
        vecs[4] = '{sel: 3'b011, a: 16'hFFFF, b: 16'd9999, r: 16'd1, exp_val: 9999};

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("after_reset");

        foreach (vecs[i])
            run_txn(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].exp_val, 1'b0, 0);

        // Press with no select: nothing must start.
        @(negedge clk);
        {is_op1, is_op2, is_res} = 3'b000;
        btn_press = 1'b1;
        @(negedge clk);
        btn_press = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_idle_outputs("nosel");
            @(negedge clk);
        end

        // Back-to-back start right after DONE, with a mid-run press and operand change.
        run_txn(3'b010, 16'd0, 16'd12345, 16'd0, 12345, 1'b1, 0);
        run_txn(3'b001, 16'd0, 16'd0, 16'd10, 10, 1'b0, 0);

        // Reset during SHIFT, then a clean transaction.
        run_txn(3'b100, 16'd54321, 16'd0, 16'd0, 54321, 1'b0, 25);
        for (int k = 0; k < 40; k++) begin
            check("abort_no_done", 32'(done), 32'd0);
            check("abort_no_busy", 32'(busy), 32'd0);
            @(negedge clk);
        end
        run_txn(3'b100, 16'd54321, 16'd0, 16'd0, 54321, 1'b0, 0);

        // Reset during CONVERT.
        run_txn(3'b001, 16'd0, 16'd0, 16'd777, 777, 1'b0, 8);
        @(negedge clk);
        check_idle_outputs("abort_conv");

        for (int t = 0; t < 20; t++) begin
            logic [2:0]  s;
            logic [15:0] ra, rb, rr;
            s  = 3'($urandom_range(1, 7));
            ra = 16'($urandom);
            rb = 16'($urandom);
            rr = 16'($urandom);
            run_txn(s, ra, rb, rr, model_select(s, ra, rb, rr), 1'($urandom_range(0, 1)), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
